hyperram_ctrl: RTL and testbench
================================

// Module: hyperram_ctrl
// PURPOSE
//  Single-clock HyperRAM transaction sequencer between the picosoc native memory bus and the
//  HyperRAM pad/IO stage. Converts one 32-bit bus access into CS/CA/latency/data phases.
//  Drives the IO stage's DDR lane pairs (_0 = first/rising byte, _1 = second byte) and direction
//  controls. Also performs the device reset/power-up wait. Fixed 2x latency; linear bursts of 2 halfwords.
// PARAMETERS
//  ADDR_W      24  byte-address width of mem_addr
//  LATENCY     6   device initial latency (clocks); fixed 2x mode
//  RST_CYC     16  cycles hyperram_rst_to_pad_ is held low after resetn release
//  RST_WAIT    400 cycles waited after RST_CYC before first access
//  CS_HIGH_CYC 2   minimum CS-high cycles between transactions
//  RD_TIMEOUT  32  max cycles in RDATA awaiting a strobe before abort
// PORTS
//  clk                      in  1      controller clock (same clock as IO stage clk)
//  resetn                   in  1      async active-low reset
//  mem_valid                in  1      bus request
//  mem_ready                out 1      1-cycle completion pulse
//  mem_addr                 in  ADDR_W byte address, bits[1:0] ignored
//  mem_wdata                in  32     write data
//  mem_wstrb                in  4      byte enables; 0 = read
//  mem_rdata                out 32     read data, valid with mem_ready
//  hram_timeout             out 1      1-cycle pulse with mem_ready on aborted read
//  hyperram_ce_to_pad_      out 1      chip select, active low
//  hyperram_rst_to_pad_     out 1      device reset, active low
//  hyperram_dq_dir          out 1      1 = drive DQ
//  hyperram_rwds_dir        out 1      1 = drive RWDS
//  hyperram_dq_to_pad_0/1   out 8 ea   DQ bytes, first/second half of clk
//  hyperram_rwds_to_pad_0/1 out 1 ea   RWDS (write mask) first/second half
//  hyperram_dq_from_pad_0/1 in  8 ea   captured DQ bytes
//  hyperram_rwds_from_pad_0/1 in 1 ea  captured RWDS
// BEHAVIOUR
//  Reset: ce_=1, rst_=0, dq_dir=0, rwds_dir=0, dq/rwds_to_pad=0, mem_ready=0, mem_rdata=0,
//   hram_timeout=0, state=RST_ASSERT. All outputs registered.
//  States: RST_ASSERT(RST_CYC, rst_=0) -> RST_WAIT(RST_WAIT, rst_=1) -> IDLE -> CA -> LAT ->
//   WDATA|RDATA -> CS_HOLD -> IDLE.
//  IDLE: when mem_valid & ~mem_ready, latch addr/wdata/wstrb; next cycle ce_=0, enter CA.
//   Requests during reset states are held off (mem_ready stays 0).
//  CA: 3 cycles, dq_dir=1, bytes CA[47:40],[39:32] / [31:24],[23:16] / [15:8],[7:0] on _0,_1.
//   CA[47]=read(wstrb==0), CA[46]=0 mem space, CA[45]=1 linear, CA[44:16]=ha[ADDR_W-2:3]
//   zero-extended, CA[15:3]=0, CA[2:0]=ha[2:0]; ha = mem_addr[ADDR_W-1:1] with ha[0]=0.
//  LAT: exactly 2*LATENCY-2 cycles (default 10); dq_dir=1 for write, 0 for read; dq=0.
//  WDATA: 2 cycles, dq_dir=1, rwds_dir=1. Halfword n (n=0,1): _0=wdata[16n+7:16n],
//   _1=wdata[16n+15:16n+8], rwds_to_pad_0=~wstrb[2n], rwds_to_pad_1=~wstrb[2n+1] (1=masked).
//  RDATA: dq_dir=0, rwds_dir=0. A halfword is valid in a cycle where rwds_from_pad_0=1 and
//   rwds_from_pad_1=0; store {from_pad_1,from_pad_0} into rdata[16n+15:16n], n increments.
//   After 2 halfwords -> CS_HOLD. Other RWDS patterns ignored.
//  Timeout: RD_TIMEOUT cycles in RDATA without both halfwords -> CS_HOLD; missing halfwords
//   read as 16'h0000; hram_timeout pulses with mem_ready.
//  CS_HOLD: ce_=1, dq_dir=0, rwds_dir=0 for CS_HIGH_CYC cycles; mem_ready pulses on the
//   first CS_HOLD cycle (mem_rdata updated same cycle, held until next read completes).
//  Back-to-back: next request accepted only in IDLE after CS_HOLD; mem_valid dropped
//   mid-transaction does not abort; transaction always completes.
//  resetn asserted mid-transaction: immediate return to reset values, full reset sequence repeats.
//  mem_ready never asserted for more than one cycle per request.
// TESTING
//  Power-up: release resetn -> rst_ low 16 cycles, high, no ce_ activity for 400 more cycles.
//  Write addr 0x000010, wdata 0xA1B2C3D4, wstrb 0xF -> CA 0x20/00/00/01/00/00 (ha=8), 10 LAT
//   cycles, data (D4,C3),(B2,A1), rwds 0/0, mem_ready one cycle after, ce_ high 2 cycles.
//  Write wstrb 0b0101 -> rwds_to_pad_0/1 = 0/1 both halfwords; CA[47]=0.
//  Read addr 0x000100 with model strobing 0x3412,0x7856 after 3 idle cycles -> CA[47]=1,
//   mem_rdata=0x78563412, hram_timeout=0.
//  Read with no RWDS strobe -> mem_ready+hram_timeout after 32 RDATA cycles, rdata=0.
//  Assert resetn during LAT -> ce_=1, rst_=0 next, no mem_ready; sequence restarts cleanly.

Source files
------------

// File: rtl/hyperram_ctrl.sv
// HyperRAM transaction sequencer between the picosoc native memory bus and the DDR pad stage.
// Runs the device power-up reset, then turns each 32-bit access into CA/latency/data phases.
module hyperram_ctrl #(
  parameter int ADDR_W      = 24,
  parameter int LATENCY     = 6,
  parameter int RST_CYC     = 16,
  parameter int RST_WAIT    = 400,
  parameter int CS_HIGH_CYC = 2,
  parameter int RD_TIMEOUT  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic              hram_timeout,
  output logic              hyperram_ce_to_pad_,
  output logic              hyperram_rst_to_pad_,
  output logic              hyperram_dq_dir,
  output logic              hyperram_rwds_dir,
  output logic [7:0]        hyperram_dq_to_pad_0,
  output logic [7:0]        hyperram_dq_to_pad_1,
  output logic              hyperram_rwds_to_pad_0,
  output logic              hyperram_rwds_to_pad_1,
  input  logic [7:0]        hyperram_dq_from_pad_0,
  input  logic [7:0]        hyperram_dq_from_pad_1,
  input  logic              hyperram_rwds_from_pad_0,
  input  logic              hyperram_rwds_from_pad_1
);

  // state         | meaning
  // ST_RST_ASSERT | device reset held low for RST_CYC cycles
  // ST_RST_WAIT   | device reset released, RST_WAIT cycles before first access
  // ST_IDLE       | waiting for a bus request
  // ST_CA         | three command/address cycles on DQ
  // ST_LAT        | fixed 2x initial latency
  // ST_WDATA      | two masked halfwords driven with RWDS
  // ST_RDATA      | capturing halfwords qualified by RWDS, bounded by RD_TIMEOUT
  // ST_CS_HOLD    | chip select high, bus completion pulse on first cycle
  typedef enum logic [2:0] {
    ST_RST_ASSERT,
    ST_RST_WAIT,
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_WDATA,
    ST_RDATA,
    ST_CS_HOLD
  } state_t;

  localparam int CNT_W   = 16;
  localparam int LAT_CYC = 2 * LATENCY - 2;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       ca_lo;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              is_rd;
  logic              hw_n;
  logic [31:0]       rdata_buf;

  logic [ADDR_W-2:0] ha;
  logic [28:0]       ca_addr;
  logic [47:0]       ca_word;
  logic              rd_req;
  logic              strobe;
  logic              rd_done;
  logic [31:0]       rdata_next;
  logic              unused_addr_lsbs;

  // Halfword address; bit 0 forced low so every access is a 32-bit aligned burst of two.
  assign ha       = {mem_addr[ADDR_W-1:2], 1'b0};
  assign rd_req   = (mem_wstrb == 4'b0000);
  assign ca_addr  = 29'(ha[ADDR_W-2:3]);
  assign ca_word  = {rd_req, 1'b0, 1'b1, ca_addr, 13'd0, ha[2:0]};
  assign strobe   = hyperram_rwds_from_pad_0 & ~hyperram_rwds_from_pad_1;
  assign rd_done  = strobe & hw_n;
  assign unused_addr_lsbs = ^mem_addr[1:0];

  always_comb begin
    rdata_next = rdata_buf;
    if (strobe) begin
      if (hw_n) rdata_next[31:16] = {hyperram_dq_from_pad_1, hyperram_dq_from_pad_0};
      else      rdata_next[15:0]  = {hyperram_dq_from_pad_1, hyperram_dq_from_pad_0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state                  <= ST_RST_ASSERT;
      cnt                    <= CNT_W'(RST_CYC - 1);
      ca_lo                  <= '0;
      wdata_q                <= '0;
      wstrb_q                <= '0;
      is_rd                  <= 1'b0;
      hw_n                   <= 1'b0;
      rdata_buf              <= '0;
      mem_ready              <= 1'b0;
      mem_rdata              <= '0;
      hram_timeout           <= 1'b0;
      hyperram_ce_to_pad_    <= 1'b1;
      hyperram_rst_to_pad_   <= 1'b0;
      hyperram_dq_dir        <= 1'b0;
      hyperram_rwds_dir      <= 1'b0;
      hyperram_dq_to_pad_0   <= '0;
      hyperram_dq_to_pad_1   <= '0;
      hyperram_rwds_to_pad_0 <= 1'b0;
      hyperram_rwds_to_pad_1 <= 1'b0;
    end else begin
      case (state)
        ST_RST_ASSERT: begin
          if (cnt == '0) begin
            state                <= ST_RST_WAIT;
            cnt                  <= CNT_W'(RST_WAIT - 1);
            hyperram_rst_to_pad_ <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_RST_WAIT: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end

        ST_IDLE: begin
          if (mem_valid && !mem_ready) begin
            state                <= ST_CA;
            cnt                  <= CNT_W'(2);
            ca_lo                <= ca_word[31:0];
            wdata_q              <= mem_wdata;
            wstrb_q              <= mem_wstrb;
            is_rd                <= rd_req;
            hw_n                 <= 1'b0;
            rdata_buf            <= '0;
            hyperram_ce_to_pad_  <= 1'b0;
            hyperram_dq_dir      <= 1'b1;
            hyperram_dq_to_pad_0 <= ca_word[47:40];
            hyperram_dq_to_pad_1 <= ca_word[39:32];
          end
        end

        ST_CA: begin
          if (cnt == '0) begin
            state                <= ST_LAT;
            cnt                  <= CNT_W'(LAT_CYC - 1);
            hyperram_dq_dir      <= ~is_rd;
            hyperram_dq_to_pad_0 <= '0;
            hyperram_dq_to_pad_1 <= '0;
          end else begin
            cnt                  <= cnt - CNT_W'(1);
            hyperram_dq_to_pad_0 <= ca_lo[31:24];
            hyperram_dq_to_pad_1 <= ca_lo[23:16];
            ca_lo                <= {ca_lo[15:0], 16'h0000};
          end
        end

        ST_LAT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (is_rd) begin
            state           <= ST_RDATA;
            cnt             <= CNT_W'(RD_TIMEOUT - 1);
            hyperram_dq_dir <= 1'b0;
          end else begin
            state                  <= ST_WDATA;
            cnt                    <= CNT_W'(1);
            hyperram_dq_dir        <= 1'b1;
            hyperram_rwds_dir      <= 1'b1;
            hyperram_dq_to_pad_0   <= wdata_q[7:0];
            hyperram_dq_to_pad_1   <= wdata_q[15:8];
            hyperram_rwds_to_pad_0 <= ~wstrb_q[0];
            hyperram_rwds_to_pad_1 <= ~wstrb_q[1];
          end
        end

        ST_WDATA: begin
          if (cnt == '0) begin
            state                  <= ST_CS_HOLD;
            cnt                    <= CNT_W'(CS_HIGH_CYC - 1);
            mem_ready              <= 1'b1;
            hyperram_ce_to_pad_    <= 1'b1;
            hyperram_dq_dir        <= 1'b0;
            hyperram_rwds_dir      <= 1'b0;
            hyperram_dq_to_pad_0   <= '0;
            hyperram_dq_to_pad_1   <= '0;
            hyperram_rwds_to_pad_0 <= 1'b0;
            hyperram_rwds_to_pad_1 <= 1'b0;
          end else begin
            cnt                    <= cnt - CNT_W'(1);
            hyperram_dq_to_pad_0   <= wdata_q[23:16];
            hyperram_dq_to_pad_1   <= wdata_q[31:24];
            hyperram_rwds_to_pad_0 <= ~wstrb_q[2];
            hyperram_rwds_to_pad_1 <= ~wstrb_q[3];
          end
        end

        ST_RDATA: begin
          if (strobe) begin
            rdata_buf <= rdata_next;
            hw_n      <= 1'b1;
          end
          // A second halfword on the last allowed cycle still counts as a clean completion.
          if (rd_done || cnt == '0) begin
            state               <= ST_CS_HOLD;
            cnt                 <= CNT_W'(CS_HIGH_CYC - 1);
            mem_ready           <= 1'b1;
            mem_rdata           <= rdata_next;
            hram_timeout        <= ~rd_done;
            hyperram_ce_to_pad_ <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_CS_HOLD: begin
          mem_ready    <= 1'b0;
          hram_timeout <= 1'b0;
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end

        default: state <= ST_RST_ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperram_ctrl.sv
// Bench for hyperram_ctrl: a transaction-level model expands each bus access into the
// expected per-cycle pad/bus picture; one compare process checks it every cycle.
module tb_hyperram_ctrl;
  localparam int ADDR_W      = 24;
  localparam int LATENCY     = 6;
  localparam int RST_CYC     = 16;
  localparam int RST_WAIT    = 400;
  localparam int CS_HIGH_CYC = 2;
  localparam int RD_TIMEOUT  = 32;
  localparam int CA_CYC      = 3;
  localparam int DATA_AT     = CA_CYC + 2 * LATENCY - 2;

  typedef logic [55:0] obs_t;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              mem_valid = 1'b0;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [31:0]       mem_wdata = '0;
  logic [3:0]        mem_wstrb = '0;
  logic [31:0]       mem_rdata;
  logic              hram_timeout;
  logic              hyperram_ce_to_pad_;
  logic              hyperram_rst_to_pad_;
  logic              hyperram_dq_dir;
  logic              hyperram_rwds_dir;
  logic [7:0]        hyperram_dq_to_pad_0;
  logic [7:0]        hyperram_dq_to_pad_1;
  logic              hyperram_rwds_to_pad_0;
  logic              hyperram_rwds_to_pad_1;
  logic [7:0]        hyperram_dq_from_pad_0 = '0;
  logic [7:0]        hyperram_dq_from_pad_1 = '0;
  logic              hyperram_rwds_from_pad_0 = 1'b0;
  logic              hyperram_rwds_from_pad_1 = 1'b0;

  hyperram_ctrl #(
    .ADDR_W(ADDR_W), .LATENCY(LATENCY), .RST_CYC(RST_CYC), .RST_WAIT(RST_WAIT),
    .CS_HIGH_CYC(CS_HIGH_CYC), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .hram_timeout(hram_timeout),
    .hyperram_ce_to_pad_(hyperram_ce_to_pad_), .hyperram_rst_to_pad_(hyperram_rst_to_pad_),
    .hyperram_dq_dir(hyperram_dq_dir), .hyperram_rwds_dir(hyperram_rwds_dir),
    .hyperram_dq_to_pad_0(hyperram_dq_to_pad_0), .hyperram_dq_to_pad_1(hyperram_dq_to_pad_1),
    .hyperram_rwds_to_pad_0(hyperram_rwds_to_pad_0), .hyperram_rwds_to_pad_1(hyperram_rwds_to_pad_1),
    .hyperram_dq_from_pad_0(hyperram_dq_from_pad_0), .hyperram_dq_from_pad_1(hyperram_dq_from_pad_1),
    .hyperram_rwds_from_pad_0(hyperram_rwds_from_pad_0),
    .hyperram_rwds_from_pad_1(hyperram_rwds_from_pad_1)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  obs_t        exp_q[$];
  bit          chk_en = 1'b0;
  bit          started = 1'b0;
  int          seq_idx = 0;
  logic [31:0] last_rdata = '0;
  logic [47:0] obs_ca;
  logic [3:0]  obs_rw;
  logic [31:0] obs_rdata;
  logic        obs_to;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic obs_t pack(input logic ce, input logic rst, input logic dqd, input logic rwd,
                                input logic [7:0] d0, input logic [7:0] d1, input logic r0,
                                input logic r1, input logic rdy, input logic to,
                                input logic [31:0] rd);
    return {ce, rst, dqd, rwd, d0, d1, r0, r1, rdy, to, rd};
  endfunction

  function automatic obs_t dut_now();
    return pack(hyperram_ce_to_pad_, hyperram_rst_to_pad_, hyperram_dq_dir, hyperram_rwds_dir,
                hyperram_dq_to_pad_0, hyperram_dq_to_pad_1, hyperram_rwds_to_pad_0,
                hyperram_rwds_to_pad_1, mem_ready, hram_timeout, mem_rdata);
  endfunction

  // Command/address word straight from the HyperBus field definitions.
  function automatic logic [47:0] model_ca(input logic [23:0] addr, input logic rd);
    logic [47:0] ha;
    ha = ({24'h0, addr} >> 1) & ~48'h1;
    return ({47'h0, rd} << 47) | (48'h1 << 45) | ((ha >> 3) << 16) | (ha & 48'h7);
  endfunction

  always @(negedge clk) begin : compare
    obs_t e;
    obs_t a;
    if (chk_en) begin
      if (!started && exp_q.size() > 0 && !hyperram_ce_to_pad_) begin
        started = 1'b1;
        seq_idx = 0;
      end
      a = dut_now();
      if (started) begin
        e = exp_q.pop_front();
        if (seq_idx < CA_CYC) obs_ca[47 - 16 * seq_idx -: 16] = {hyperram_dq_to_pad_0, hyperram_dq_to_pad_1};
        if (seq_idx == DATA_AT)     obs_rw[1:0] = {hyperram_rwds_to_pad_1, hyperram_rwds_to_pad_0};
        if (seq_idx == DATA_AT + 1) obs_rw[3:2] = {hyperram_rwds_to_pad_1, hyperram_rwds_to_pad_0};
        if (mem_ready) begin
          obs_rdata = mem_rdata;
          obs_to    = hram_timeout;
        end
        chk($sformatf("txn cycle %0d", seq_idx), a, e);
        seq_idx++;
        if (exp_q.size() == 0) begin
          started    = 1'b0;
          last_rdata = e[31:0];
        end
      end else begin
        chk("idle outputs", a, pack(1, 1, 0, 0, 8'h0, 8'h0, 0, 0, 0, 0, last_rdata));
      end
    end
  end

  task automatic set_pad(input logic r0, input logic r1, input logic [15:0] hw);
    hyperram_rwds_from_pad_0 = r0;
    hyperram_rwds_from_pad_1 = r1;
    hyperram_dq_from_pad_0   = hw[7:0];
    hyperram_dq_from_pad_1   = hw[15:8];
  endtask

  task automatic power_up();
    int n;
    chk_en = 1'b0;
    started = 1'b0;
    exp_q.delete();
    mem_valid = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset values", dut_now(), pack(1, 0, 0, 0, 8'h0, 8'h0, 0, 0, 0, 0, 32'h0));
    @(posedge clk);
    #1 resetn = 1'b1;
    n = 0;
    while (!hyperram_rst_to_pad_ && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("rst_ low cycles", n, RST_CYC);
    last_rdata = '0;
    chk_en = 1'b1;
  endtask

  // s0/s1: RDATA cycle carrying halfword 0/1 (-1 = never). abort_at: cycle to pull resetn (-1 = none).
  task automatic run_txn(input logic [23:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                         input logic [15:0] h0, input logic [15:0] h1, input int s0, input int s1,
                         input int abort_at, input bit drop_valid, output int wait_cyc);
    logic        rd;
    logic        to;
    logic [47:0] ca;
    logic [31:0] newrd;
    int          cs_at;
    int          n;
    int          k;
    rd = (ws == 4'b0000);
    ca = model_ca(addr, rd);
    if (!rd)                  cs_at = DATA_AT + 2;
    else if (s0 >= 0 && s1 >= 0) cs_at = DATA_AT + s1 + 1;
    else                      cs_at = DATA_AT + RD_TIMEOUT;
    to    = rd && !(s0 >= 0 && s1 >= 0);
    newrd = rd ? {(s1 >= 0) ? h1 : 16'h0, (s0 >= 0) ? h0 : 16'h0} : last_rdata;
    obs_ca = 'x; obs_rw = 'x; obs_rdata = 'x; obs_to = 1'bx;
    for (int i = 0; i <= cs_at + 1; i++) begin
      n = i - DATA_AT;
      if (i < CA_CYC)
        exp_q.push_back(pack(0, 1, 1, 0, ca[47 - 16 * i -: 8], ca[39 - 16 * i -: 8], 0, 0, 0, 0, last_rdata));
      else if (i < DATA_AT)
        exp_q.push_back(pack(0, 1, !rd, 0, 8'h0, 8'h0, 0, 0, 0, 0, last_rdata));
      else if (i < cs_at && rd)
        exp_q.push_back(pack(0, 1, 0, 0, 8'h0, 8'h0, 0, 0, 0, 0, last_rdata));
      else if (i < cs_at)
        exp_q.push_back(pack(0, 1, 1, 1, wd[16 * n +: 8], wd[16 * n + 8 +: 8], ~ws[2 * n],
                             ~ws[2 * n + 1], 0, 0, last_rdata));
      else if (i == cs_at)
        exp_q.push_back(pack(1, 1, 0, 0, 8'h0, 8'h0, 0, 0, 1, to, newrd));
      else
        exp_q.push_back(pack(1, 1, 0, 0, 8'h0, 8'h0, 0, 0, 0, 0, newrd));
    end
    @(negedge clk);
    mem_addr = addr; mem_wdata = wd; mem_wstrb = ws; mem_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (hyperram_ce_to_pad_ && k < 600);
    wait_cyc = k;
    if (hyperram_ce_to_pad_) begin
      chk("ce_ low within bound", hyperram_ce_to_pad_, 1'b0);
      chk_en = 1'b0; started = 1'b0; exp_q.delete(); mem_valid = 1'b0;
      return;
    end
    for (int i = 0; i <= cs_at + 1; i++) begin
      if (i == abort_at) begin
        chk_en = 1'b0; started = 1'b0; exp_q.delete();
        resetn = 1'b0; mem_valid = 1'b0;
        #1 chk("async reset mid-transaction", dut_now(), pack(1, 0, 0, 0, 8'h0, 8'h0, 0, 0, 0, 0, 32'h0));
        repeat (2) begin
          @(negedge clk);
          chk("held in reset", {hyperram_ce_to_pad_, hyperram_rst_to_pad_, mem_ready}, 3'b100);
        end
        set_pad(0, 0, 16'h0);
        return;
      end
      if (rd && i >= DATA_AT) begin
        if (i - DATA_AT == s0)      set_pad(1, 0, h0);
        else if (i - DATA_AT == s1) set_pad(1, 0, h1);
        else                        set_pad(i[0], 1, 16'h5AEE);
      end else if (rd && i >= CA_CYC) begin
        set_pad(1, 0, 16'hBBBB);
      end else begin
        set_pad(0, 0, 16'h0);
      end
      if (drop_valid && i == 1) mem_valid = 1'b0;
      if (mem_ready) mem_valid = 1'b0;
      @(negedge clk);
    end
    set_pad(0, 0, 16'h0);
    mem_valid = 1'b0;
    chk("expectations drained", exp_q.size(), 0);
  endtask

  initial begin : main
    int wc;
    power_up();
    run_txn(24'h000010, 32'hA1B2C3D4, 4'hF, 16'h0, 16'h0, -1, -1, -1, 1'b0, wc);
    chk("power-up wait to ce_ low", wc, RST_WAIT + 1);
    chk("write CA literal", obs_ca, 48'h2000_0001_0000);
    chk("write full mask literal", obs_rw, 4'b0000);

    run_txn(24'h000024, 32'h11223344, 4'b0101, 16'h0, 16'h0, -1, -1, -1, 1'b1, wc);
    chk("accept latency", wc, 1);
    chk("write partial mask literal", obs_rw, 4'b1010);

    run_txn(24'h000100, 32'h0, 4'h0, 16'h3412, 16'h7856, 3, 4, -1, 1'b0, wc);
    chk("read CA literal", obs_ca, 48'hA000_0010_0000);
    chk("read data literal", obs_rdata, 32'h78563412);
    chk("read timeout flag", obs_to, 1'b0);

    run_txn(24'h000200, 32'h0, 4'h0, 16'h0, 16'h0, -1, -1, -1, 1'b0, wc);
    chk("timeout read data", obs_rdata, 32'h0);
    chk("timeout flag", obs_to, 1'b1);

    run_txn(24'hFFFFFC, 32'h0, 4'h0, 16'hBEEF, 16'h0, 5, -1, -1, 1'b0, wc);
    chk("high addr CA literal", obs_ca, 48'hA00F_FFFF_0006);
    chk("partial timeout data", obs_rdata, 32'h0000BEEF);

    run_txn(24'h000404, 32'h0, 4'h0, 16'hCAFE, 16'h1234, 0, RD_TIMEOUT - 1, -1, 1'b0, wc);
    chk("last-cycle strobe data", obs_rdata, 32'h1234CAFE);
    chk("last-cycle strobe no timeout", obs_to, 1'b0);

    run_txn(24'h000008, 32'hDEADBEEF, 4'b1000, 16'h0, 16'h0, -1, -1, -1, 1'b0, wc);
    chk("single byte mask literal", obs_rw, 4'b0111);

    run_txn(24'h000040, 32'h55AA55AA, 4'hF, 16'h0, 16'h0, -1, -1, 5, 1'b0, wc);
    power_up();
    run_txn(24'h000010, 32'h0BADF00D, 4'hF, 16'h0, 16'h0, -1, -1, -1, 1'b0, wc);
    chk("power-up wait after abort", wc, RST_WAIT + 1);
    run_txn(24'h000080, 32'h0, 4'h0, 16'h0F0F, 16'hF0F0, 1, 2, -1, 1'b0, wc);
    chk("read after abort", obs_rdata, 32'hF0F00F0F);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d",
             vectors, miscompares + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
